// File: rtl/lane_activity_pkg.sv
// Shared types and sizing helpers for the lane activity stretcher.
package lane_activity_pkg;

  typedef enum logic {LS_IDLE = 1'b0, LS_HOLD = 1'b1} lane_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Hold counter must be at least one bit, even for STRETCH=1.
  function automatic int hold_w(input int stretch);
    return (clog2(stretch) < 1) ? 1 : clog2(stretch);
  endfunction

endpackage

// File: rtl/lane_activity_stretcher_fsm.sv
// Per-lane pulse stretcher: IDLE/HOLD FSM with a retriggerable hold counter.
module lane_stretch_fsm
  import lane_activity_pkg::*;
#(
  parameter int STRETCH = 8
) (
  input  logic C,
  input  logic RN,
  input  logic rise,
  output logic o_bit,
  output logic o_nxt
);

  localparam int HOLD_W = hold_w(STRETCH);
  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(STRETCH - 1);

  lane_state_t       state, nxt_state;
  logic [HOLD_W-1:0] cnt, nxt_cnt;

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state <= LS_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      LS_IDLE: begin
        if (rise) begin
          nxt_state = LS_HOLD;
          nxt_cnt   = RELOAD;
        end
      end
      LS_HOLD: begin
        if (rise) begin
          nxt_cnt = RELOAD;
        end else if (cnt == '0) begin
          nxt_state = LS_IDLE;
        end else begin
          nxt_cnt = cnt - HOLD_W'(1);
        end
      end
      default: nxt_state = LS_IDLE;
    endcase
  end

  // o is a state decode, so it comes straight off the state flop.
  always_comb begin
    o_bit = (state == LS_HOLD);
    o_nxt = (nxt_state == LS_HOLD);
  end

endmodule

// File: rtl/lane_activity_stretcher.sv
// Lane activity stretcher top: input sync, rise detect, per-lane stretch FSMs,
// busy flag and saturating edge counter. LANE_GLITCH_FILTER_EN adds a 2-sample filter.
module lane_activity_stretcher
  import lane_activity_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int STRETCH = 8,
  parameter int CNT_W   = 8
) (
  input  logic             C,
  input  logic             RN,
  input  logic [LANES-1:0] i,
  output logic [LANES-1:0] o,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int POP_W = clog2(LANES + 1);
  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [LANES-1:0] s1, s2, s3, rise, o_nxt;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_nxt;

`ifdef LANE_GLITCH_FILTER_EN
  logic [LANES-1:0] s4;

  always_ff @(posedge C or negedge RN) begin
    if (!RN) s4 <= '0;
    else     s4 <= s3;
  end

  // Two consecutive high synced samples required before an edge counts.
  assign rise = s2 & s3 & ~s4;
`else
  assign rise = s2 & ~s3;
`endif

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    pop = '0;
    for (int l = 0; l < LANES; l++) pop = pop + POP_W'(rise[l]);
  end

  // Sum is wide enough for the worst case, so the clamp is a plain compare.
  always_comb begin
    sum     = SUM_W'(edge_cnt) + SUM_W'(pop);
    cnt_nxt = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      edge_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      edge_cnt <= cnt_nxt;
      busy     <= |o_nxt;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_stretch_fsm #(.STRETCH(STRETCH)) u_lane (
      .C     (C),
      .RN    (RN),
      .rise  (rise[g]),
      .o_bit (o[g]),
      .o_nxt (o_nxt[g])
    );
  end

endmodule

// File: tb/tb_lane_activity_stretcher.sv
// Bench for lane_activity_stretcher: vector table, corner sequences and random
// traffic against a sample-history reference model.
module tb_lane_activity_stretcher;

  localparam int L  = 4;
  localparam int ST = 8;
`ifdef LANE_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif

  logic         C, RN;
  logic [L-1:0] i;
  logic [L-1:0] o, o3;
  logic         busy, busy3;
  logic [7:0]   edge_cnt;
  logic [2:0]   edge_cnt3;

  lane_activity_stretcher #(.LANES(L), .STRETCH(ST), .CNT_W(8)) dut (
    .C(C), .RN(RN), .i(i), .o(o), .busy(busy), .edge_cnt(edge_cnt));

  lane_activity_stretcher #(.LANES(L), .STRETCH(ST), .CNT_W(3)) dut3 (
    .C(C), .RN(RN), .i(i), .o(o3), .busy(busy3), .edge_cnt(edge_cnt3));

  initial C = 1'b0;
  always #5 C = ~C;

  int total = 0;
  int bad   = 0;

  // Model: samp[n] is the value of i at the n-th clock edge since reset release.
  logic [L-1:0] samp [0:1023];
  int n   = 0;
  int tot = 0;

  function automatic logic [L-1:0] v(input int x);
    return (x < 1) ? '0 : samp[x];
  endfunction

  // Edge seen by the design after clock edge m, applied at edge m+1.
  function automatic logic [L-1:0] rise_after(input int m);
    if (m < 1) return '0;
    if (FILT != 0) return v(m-1) & v(m-2) & ~v(m-3);
    return v(m-1) & ~v(m-2);
  endfunction

  // A lane is high while its most recent edge is within the last ST edges.
  function automatic logic [L-1:0] o_model();
    logic [L-1:0] r;
    r = '0;
    for (int m = n - ST; m <= n - 1; m++) r |= rise_after(m);
    return r;
  endfunction

  function automatic int cap(input int x, input int mx);
    return (x < mx) ? x : mx;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, n);
    end
  endtask

  task automatic tick(input logic [L-1:0] iv);
    logic [L-1:0] eo;
    @(negedge C);
    i = iv;
    @(posedge C);
    n++;
    if (n > 1000) begin
      $display("FAIL model_depth: got %0d want <=1000", n);
      $fatal(1);
    end
    samp[n] = iv;
    tot += $countones(rise_after(n - 1));
    #2;
    eo = o_model();
    chk("o", o, eo);
    chk("busy", busy, |eo);
    chk("edge_cnt", edge_cnt, cap(tot, 255));
    chk("edge_cnt3", edge_cnt3, cap(tot, 7));
  endtask

  task automatic release_rst();
    @(posedge C);
    #2;
    RN  = 1'b1;
    n   = 0;
    tot = 0;
  endtask

  task automatic do_reset();
    @(negedge C);
    RN = 1'b0;
    #1;
    chk("rst_o", o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", edge_cnt, 0);
    chk("rst_cnt3", edge_cnt3, 0);
    release_rst();
  endtask

  typedef struct {
    logic [L-1:0] iv;
    logic [L-1:0] o_exp;
    logic [7:0]   cnt_exp;
  } vec_t;

  vec_t tbl [16];
  int hi, hi2, maxinc, first;
  logic [7:0] prev;
  logic [L-1:0] cur;

  initial begin
    // Test 1 table: 3-cycle pulse on lane 0, seen from edge 3 (+1 with filter).
    for (int t = 0; t < 16; t++) begin
      tbl[t].iv      = (t + 1 <= 3) ? 4'b0001 : 4'b0000;
      tbl[t].o_exp   = (t + 1 >= 3 + FILT && t + 1 <= 10 + FILT) ? 4'b0001 : 4'b0000;
      tbl[t].cnt_exp = (t + 1 >= 3 + FILT) ? 8'd1 : 8'd0;
    end

    RN = 1'b0;
    i  = '0;
    repeat (2) @(posedge C);
    #2;
    chk("init_o", o, 0);
    chk("init_busy", busy, 0);
    chk("init_cnt", edge_cnt, 0);
    release_rst();

    for (int t = 0; t < 16; t++) begin
      tick(tbl[t].iv);
      chk("t1_o", o, tbl[t].o_exp);
      chk("t1_busy", busy, |tbl[t].o_exp);
      chk("t1_cnt", edge_cnt, tbl[t].cnt_exp);
    end

    // Test 2: retrigger 5 cycles into HOLD keeps o[2] high 5+8 cycles.
    do_reset();
    hi = 0;
    for (int k = 1; k <= 20; k++) begin
      tick((k <= 2 || k >= 6) ? 4'b0100 : 4'b0000);
      if (o[2]) hi++;
    end
    chk("t2_hi", hi, 13);
    chk("t2_cnt", edge_cnt, 2);

    // Test 3: all lanes rise together.
    do_reset();
    hi = 0; maxinc = 0; prev = 0;
    for (int k = 1; k <= 16; k++) begin
      tick((k <= 2) ? 4'hF : 4'h0);
      if (o == 4'hF) hi++;
      if (int'(edge_cnt) - int'(prev) > maxinc) maxinc = int'(edge_cnt) - int'(prev);
      prev = edge_cnt;
    end
    chk("t3_hiF", hi, 8);
    chk("t3_cnt", edge_cnt, 4);
    chk("t3_step", maxinc, 4);

    // Test 4: ten edges saturate the 3-bit counter.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick(4'b0001); tick(4'b0001); tick(4'b0000); tick(4'b0000);
    end
    repeat (12) tick(4'b0000);
    chk("t4_cnt3", edge_cnt3, 7);
    chk("t4_cnt", edge_cnt, 10);

    // Test 5: reset mid-HOLD with i[1] held high.
    do_reset();
    repeat (6) tick(4'b0010);
    chk("t5_pre_o1", o[1], 1);
    do_reset();
    hi = 0;
    for (int k = 0; k < 15; k++) begin
      tick(4'b0010);
      if (o[1]) hi++;
    end
    chk("t5_hi", hi, 8);
    chk("t5_cnt", edge_cnt, 1);

`ifdef LANE_GLITCH_FILTER_EN
    // Test 6: single-sample glitch rejected, two-sample high accepted at k+3.
    do_reset();
    hi = 0;
    tick(4'h0); tick(4'h8);
    repeat (10) begin tick(4'h0); if (o[3]) hi++; end
    chk("t6_glitch_o", hi, 0);
    chk("t6_glitch_cnt", edge_cnt, 0);
    first = 0;
    hi2 = n + 1;
    tick(4'h8); tick(4'h8);
    for (int k = 0; k < 12; k++) begin
      tick(4'h0);
      if (o[3] && first == 0) first = n;
    end
    chk("t6_lat", first, hi2 + 3);
    chk("t6_cnt", edge_cnt, 1);
`endif

    // Random traffic: sparse toggles, a burst of fast toggling, a mid-run reset.
    do_reset();
    cur = '0;
    for (int k = 0; k < 400; k++) begin
      if (k == 200) do_reset();
      if (k >= 100 && k < 140) cur = L'($urandom);
      else cur ^= L'($urandom & $urandom & $urandom);
      tick(cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
